// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   RF_AW / RF_DW : default register address / data widths (match the RF)
//   RF_DEPTH      : number of architectural registers (2**RF_AW)
//   clog2w()      : index width that never collapses to zero bits (n=1 -> 1)
//   wb_req_t      : one write-back request {wa, wd} at the default widths
package rf_wb_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 2**RF_AW;

  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [RF_AW-1:0] wa;
    logic [RF_DW-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/rf_rr_arb.sv
// Round-robin arbiter for the write-back sources.
// The search starts one past the last granted index and wraps modulo N.
// The pointer moves to the granted index only when advance is high.
// Ports:
//   clk, rstn    clock, async active-low reset (pointer resets to N-1)
//   req [N]      requests (already masked by stall/reset upstream)
//   advance      a grant was accepted this cycle
//   gnt [N]      one-hot grant or zero
//   idx [GW]     index of the granted requester (0 when none)
module rf_rr_arb
  import rf_wb_pkg::*;
#(
  parameter int N = 3,
  localparam int GW = clog2w(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [GW-1:0] idx
);

  logic [GW-1:0] ptr_q, ptr_d;
  logic          found;
  int            cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = GW'(cand);
        found     = 1'b1;
      end
    end
  end

  assign ptr_d = advance ? idx : ptr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= GW'(N - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: NREQ write-back sources share one RF
// write port through a round-robin grant and a single registered stage.
// Optional pending-write scoreboard enabled by defining RF_WB_SCOREBOARD_EN.
// Ports:
//   clk, rstn              clock, async active-low reset
//   req_valid/req_ready    per-source handshake (ready one-hot or zero)
//   req_wa/req_wd          packed per-source address/data, slice i = [i*W +: W]
//   rf_stall               RF port busy: hold the stage, grant nothing
//   rf_we/rf_wa/rf_wd      registered RF write port
//   grant_id               source of the write currently on rf_*
//   claim_valid/claim_wa   (scoreboard) reserve a destination register
//   busy                   (scoreboard) pending-write vector
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW,
  localparam int GW  = clog2w(NREQ)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_wa,
  input  logic [NREQ*DW-1:0] req_wd,
  input  logic             rf_stall,
  output logic             rf_we,
  output logic [AW-1:0]    rf_wa,
  output logic [DW-1:0]    rf_wd,
  output logic [GW-1:0]    grant_id
`ifdef RF_WB_SCOREBOARD_EN
  ,
  input  logic             claim_valid,
  input  logic [AW-1:0]    claim_wa,
  output logic [2**AW-1:0] busy
`endif
);

  logic [NREQ-1:0] arb_req, gnt;
  logic [GW-1:0]   idx;
  logic            advance;
  logic [AW-1:0]   sel_wa;
  logic [DW-1:0]   sel_wd;

  logic            we_q, we_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic [GW-1:0]   id_q, id_d;

  // Gating with rstn keeps ready low while reset is asserted.
  assign arb_req   = (rstn && !rf_stall) ? req_valid : '0;
  assign req_ready = gnt;
  assign advance   = |gnt;

  rf_rr_arb #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (arb_req),
    .advance (advance),
    .gnt     (gnt),
    .idx     (idx)
  );

  always_comb begin
    sel_wa = '0;
    sel_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_wa = req_wa[i*AW +: AW];
        sel_wd = req_wd[i*DW +: DW];
      end
    end
  end

  // Stage empties every unstalled cycle; writes to r0 are accepted but
  // never raise we.
  always_comb begin
    we_d = we_q;
    wa_d = wa_q;
    wd_d = wd_q;
    id_d = id_q;
    if (!rf_stall) begin
      we_d = advance && (sel_wa != '0);
      if (advance) begin
        wa_d = sel_wa;
        wd_d = sel_wd;
        id_d = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      id_q <= '0;
    end else begin
      we_q <= we_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      id_q <= id_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_wa    = wa_q;
  assign rf_wd    = wd_q;
  assign grant_id = id_q;

`ifdef RF_WB_SCOREBOARD_EN
  logic [2**AW-1:0] busy_q, busy_d;

  // A write only lands when the RF is not stalled; a same-cycle claim of
  // the same register wins because a newer producer is outstanding.
  always_comb begin
    busy_d = busy_q;
    if (we_q && !rf_stall) busy_d[wa_q] = 1'b0;
    if (claim_valid)       busy_d[claim_wa] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;
`endif

endmodule
